gate_response_checker: RTL and testbench

- Synthesizable response checker that sits on the output end of a gate-level DUT, opposite the stimulus driver.
- Samples the DUT inputs (a, b) and output (y) on a valid strobe and compares y against a golden 2-input gate function.
- Accumulates a saturating error count, a 4-point input-combination coverage map and the first-failure record.
- Reports done/pass after a fixed number of samples, so gate benches can self-check without waveform inspection.

---
 rtl/gate_chk_pkg.sv | 33 +++
 rtl/gate_response_checker_golden.sv | 16 +
 rtl/gate_response_checker.sv | 172 +++++++++++++++++
 tb/tb_gate_response_checker.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared encodings for the gate response checker: golden-function opcodes,
// checker FSM states and the reference gate evaluation.
package gate_chk_pkg;

  localparam logic [2:0] GATE_AND  = 3'd0;
  localparam logic [2:0] GATE_OR   = 3'd1;
  localparam logic [2:0] GATE_NAND = 3'd2;
  localparam logic [2:0] GATE_NOR  = 3'd3;
  localparam logic [2:0] GATE_XOR  = 3'd4;
  localparam logic [2:0] GATE_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reserved opcodes fall back to AND so an out-of-range OP still checks something.
  function automatic logic gate_eval(input logic [2:0] op, input logic a, input logic b);
    logic r;
    case (op)
      GATE_AND:  r = a & b;
      GATE_OR:   r = a | b;
      GATE_NAND: r = ~(a & b);
      GATE_NOR:  r = ~(a | b);
      GATE_XOR:  r = a ^ b;
      GATE_XNOR: r = ~(a ^ b);
      default:   r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_response_checker_golden.sv
// Purely combinational golden 2-input gate, reusable by any gate bench.
module gate_golden_model
  import gate_chk_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic       i_a,
  input  logic       i_b,
  output logic       o_exp
);

  // Expected gate output for the selected function.
  always_comb begin
    o_exp = gate_eval(i_op, i_a, i_b);
  end

endmodule

// File: rtl/gate_response_checker.sv
// Response checker for a 2-input gate DUT: compares y against the golden gate
// on each accepted sample and reports errors, coverage and the first failure.
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int OP          = 0,
  parameter int NUM_SAMPLES = 16,
  parameter int IDX_W       = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             smp_valid,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       coverage,
  output logic             first_err_vld,
  output logic [IDX_W-1:0] first_err_idx,
  output logic [1:0]       first_err_ab
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [2:0]       OP_SEL   = 3'(OP);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_smp_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_err_cnt;
  logic [3:0]       r_coverage;
  logic             r_first_err_vld;
  logic [IDX_W-1:0] r_first_err_idx;
  logic [1:0]       r_first_err_ab;

  logic             w_exp;
  logic             w_accept;
  logic             w_start_run;
  logic             w_fail;
  logic             w_last;
  logic [3:0]       w_cov_bit;
  logic [3:0]       w_cov_nxt;
  logic [CNT_W-1:0] w_err_nxt;

  gate_golden_model u_golden (
    .i_op  (OP_SEL),
    .i_a   (a),
    .i_b   (b),
    .o_exp (w_exp)
  );

  // Sample qualification and next-value statistics for the current cycle.
  always_comb begin
    w_accept    = smp_valid && (r_state == ST_RUN);
    w_start_run = start && (r_state != ST_RUN);
    w_fail      = w_accept && (y != w_exp);
    w_last      = w_accept && (r_smp_idx == LAST_IDX);
    w_cov_bit   = 4'b0001 << {a, b};
    if (w_accept) begin
      w_cov_nxt = r_coverage | w_cov_bit;
    end else begin
      w_cov_nxt = r_coverage;
    end
    if (w_fail && (r_err_cnt != CNT_MAX)) begin
      w_err_nxt = r_err_cnt + CNT_W'(1);
    end else begin
      w_err_nxt = r_err_cnt;
    end
  end

  // Run-control FSM transitions; start is only honoured outside RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Run statistics: cleared on run entry, updated once per accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp_idx       <= {IDX_W{1'b0}};
      r_err_cnt       <= {CNT_W{1'b0}};
      r_coverage      <= 4'h0;
      r_mismatch      <= 1'b0;
      r_pass          <= 1'b0;
      r_first_err_vld <= 1'b0;
      r_first_err_idx <= {IDX_W{1'b0}};
      r_first_err_ab  <= 2'b00;
    end else if (w_start_run) begin
      r_smp_idx       <= {IDX_W{1'b0}};
      r_err_cnt       <= {CNT_W{1'b0}};
      r_coverage      <= 4'h0;
      r_mismatch      <= 1'b0;
      r_pass          <= 1'b0;
      r_first_err_vld <= 1'b0;
      r_first_err_idx <= {IDX_W{1'b0}};
      r_first_err_ab  <= 2'b00;
    end else if (w_accept) begin
      r_smp_idx  <= r_smp_idx + IDX_W'(1);
      r_err_cnt  <= w_err_nxt;
      r_coverage <= w_cov_nxt;
      r_mismatch <= w_fail;
      if (w_fail && !r_first_err_vld) begin
        r_first_err_vld <= 1'b1;
        r_first_err_idx <= r_smp_idx;
        r_first_err_ab  <= {a, b};
      end
      // The final sample is folded into the verdict on the same edge.
      if (w_last) begin
        r_pass <= (w_cov_nxt == 4'hF) && (w_err_nxt == {CNT_W{1'b0}});
      end
    end else begin
      r_mismatch <= 1'b0;
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign mismatch      = r_mismatch;
  assign err_cnt       = r_err_cnt;
  assign coverage      = r_coverage;
  assign first_err_vld = r_first_err_vld;
  assign first_err_idx = r_first_err_idx;
  assign first_err_ab  = r_first_err_ab;

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench: three checker instances (AND/4, XOR/3, AND/8 with a 2-bit
// counter) driven independently and compared against a truth-table model.
module tb_gate_response_checker;

  localparam int ND = 3;

  typedef struct {
    int       stamp;
    int       err;
    bit [3:0] cov;
    bit       fvld;
    int       fidx;
    bit [1:0] fab;
    bit       busy;
    bit       done;
    bit       pass;
    bit       mis;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [ND-1:0] st_i = '0;
  logic [ND-1:0] v_i  = '0;
  logic [ND-1:0] a_i  = '0;
  logic [ND-1:0] b_i  = '0;
  logic [ND-1:0] y_i  = '0;

  logic [ND-1:0]      busy_o, done_o, pass_o, mis_o, fvld_o;
  logic [ND-1:0][3:0] cov_o;
  logic [ND-1:0][7:0] fidx_o;
  logic [ND-1:0][1:0] fab_o;
  logic [7:0]         err0_s, err1_s;
  logic [1:0]         err2_s;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int       m_state [ND];   // 0 idle, 1 run, 2 done
  int       m_idx   [ND];
  int       m_err   [ND];
  bit [3:0] m_cov   [ND];
  bit       m_fvld  [ND];
  int       m_fidx  [ND];
  bit [1:0] m_fab   [ND];
  bit [ND-1:0] prev_done = '0;
  rec_t     mq [ND][$];
  rec_t     dq [ND][$];

  gate_response_checker #(.OP(0), .NUM_SAMPLES(4), .IDX_W(8), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(st_i[0]), .smp_valid(v_i[0]), .a(a_i[0]), .b(b_i[0]),
    .y(y_i[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .mismatch(mis_o[0]),
    .err_cnt(err0_s), .coverage(cov_o[0]), .first_err_vld(fvld_o[0]),
    .first_err_idx(fidx_o[0]), .first_err_ab(fab_o[0]));

  gate_response_checker #(.OP(4), .NUM_SAMPLES(3), .IDX_W(8), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(st_i[1]), .smp_valid(v_i[1]), .a(a_i[1]), .b(b_i[1]),
    .y(y_i[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .mismatch(mis_o[1]),
    .err_cnt(err1_s), .coverage(cov_o[1]), .first_err_vld(fvld_o[1]),
    .first_err_idx(fidx_o[1]), .first_err_ab(fab_o[1]));

  gate_response_checker #(.OP(0), .NUM_SAMPLES(8), .IDX_W(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(st_i[2]), .smp_valid(v_i[2]), .a(a_i[2]), .b(b_i[2]),
    .y(y_i[2]), .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .mismatch(mis_o[2]),
    .err_cnt(err2_s), .coverage(cov_o[2]), .first_err_vld(fvld_o[2]),
    .first_err_idx(fidx_o[2]), .first_err_ab(fab_o[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int op_of(input int d);
    return (d == 1) ? 4 : 0;
  endfunction

  function automatic int n_of(input int d);
    case (d)
      0: return 4;
      1: return 3;
      default: return 8;
    endcase
  endfunction

  function automatic int cmax_of(input int d);
    return (d == 2) ? 3 : 255;
  endfunction

  function automatic int err_of(input int d);
    case (d)
      0: return int'(err0_s);
      1: return int'(err1_s);
      default: return int'(err2_s);
    endcase
  endfunction

  // Truth tables indexed by {a,b}.
  function automatic bit gold(input int op, input bit a, input bit b);
    bit [3:0] tt;
    case (op)
      1: tt = 4'b1110;
      2: tt = 4'b0111;
      3: tt = 4'b0001;
      4: tt = 4'b0110;
      5: tt = 4'b1001;
      default: tt = 4'b1000;
    endcase
    return tt[{a, b}];
  endfunction

  function automatic void chk(input string name, input int d, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, d, got, exp, $time);
    end
  endfunction

  function automatic rec_t zero_rec();
    rec_t r;
    r.stamp = 0; r.err = 0; r.cov = 4'h0; r.fvld = 1'b0; r.fidx = 0; r.fab = 2'b00;
    r.busy = 1'b0; r.done = 1'b0; r.pass = 1'b0; r.mis = 1'b0;
    return r;
  endfunction

  function automatic void cmp_outputs(input int d, input string tag, input rec_t e);
    chk({tag, "_busy"}, d, busy_o[d], e.busy);
    chk({tag, "_done"}, d, done_o[d], e.done);
    chk({tag, "_pass"}, d, pass_o[d], e.pass);
    chk({tag, "_mismatch"}, d, mis_o[d], e.mis);
    chk({tag, "_err_cnt"}, d, err_of(d), e.err);
    chk({tag, "_coverage"}, d, cov_o[d], e.cov);
    chk({tag, "_first_vld"}, d, fvld_o[d], e.fvld);
    chk({tag, "_first_idx"}, d, fidx_o[d], e.fidx);
    chk({tag, "_first_ab"}, d, fab_o[d], e.fab);
  endfunction

  function automatic void model_clear(input int d);
    m_idx[d] = 0; m_err[d] = 0; m_cov[d] = 4'h0;
    m_fvld[d] = 1'b0; m_fidx[d] = 0; m_fab[d] = 2'b00;
  endfunction

  // Reference behaviour for the inputs about to be clocked; responses are
  // queued with the cycle in which they must become visible.
  function automatic void model_step(input int d);
    rec_t r;
    bit   fail;
    if (st_i[d] && m_state[d] != 1) begin
      model_clear(d);
      m_state[d] = 1;
    end else if (v_i[d] && m_state[d] == 1) begin
      fail = (y_i[d] != gold(op_of(d), a_i[d], b_i[d]));
      m_cov[d][{a_i[d], b_i[d]}] = 1'b1;
      if (fail) begin
        if (m_err[d] < cmax_of(d)) m_err[d] = m_err[d] + 1;
        if (!m_fvld[d]) begin
          m_fvld[d] = 1'b1; m_fidx[d] = m_idx[d]; m_fab[d] = {a_i[d], b_i[d]};
        end
      end
      m_idx[d] = m_idx[d] + 1;
      if (m_idx[d] == n_of(d)) m_state[d] = 2;
      r.stamp = cyc + 1; r.err = m_err[d]; r.cov = m_cov[d]; r.fvld = m_fvld[d];
      r.fidx = m_fidx[d]; r.fab = m_fab[d]; r.busy = (m_state[d] == 1);
      r.done = (m_state[d] == 2); r.mis = fail;
      r.pass = (m_state[d] == 2) && (m_cov[d] == 4'hF) && (m_err[d] == 0);
      if (fail) mq[d].push_back(r);
      if (m_state[d] == 2) dq[d].push_back(r);
    end
  endfunction

  task automatic tick();
    for (int d = 0; d < ND; d++) model_step(d);
    @(negedge clk);
    st_i = '0;
    v_i  = '0;
  endtask

  task automatic smp_y(input int d, input bit a, input bit b, input bit y);
    v_i[d] = 1'b1; a_i[d] = a; b_i[d] = b; y_i[d] = y;
  endtask

  task automatic smp(input int d, input bit a, input bit b, input bit flip);
    smp_y(d, a, b, gold(op_of(d), a, b) ^ flip);
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
  task automatic do_reset();
    rec_t z;
    z = zero_rec();
    rst = 1'b1;
    #2;
    for (int d = 0; d < ND; d++) begin
      cmp_outputs(d, "reset", z);
      model_clear(d);
      m_state[d] = 0;
      mq[d].delete();
      dq[d].delete();
    end
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops an expectation whenever the DUT shows mismatch or a done rise.
  always @(negedge clk) begin
    rec_t r;
    bit   rise;
    if (!rst) begin
      for (int d = 0; d < ND; d++) begin
        rise = done_o[d] && !prev_done[d];
        if (mq[d].size() > 0 && mq[d][0].stamp == cyc) begin
          r = mq[d].pop_front();
          chk("mismatch_pulse", d, mis_o[d], 1);
          cmp_outputs(d, "fail_sample", r);
        end else begin
          chk("mismatch_quiet", d, mis_o[d], 0);
        end
        if (dq[d].size() > 0 && dq[d][0].stamp == cyc) begin
          r = dq[d].pop_front();
          chk("done_rise", d, rise, 1);
          cmp_outputs(d, "run_end", r);
        end else begin
          chk("done_no_rise", d, rise, 0);
        end
        prev_done[d] = done_o[d];
      end
    end
  end

  initial begin
    rec_t e;
    for (int d = 0; d < ND; d++) begin
      model_clear(d);
      m_state[d] = 0;
    end
    #1 rst = 1'b1;
    @(negedge clk);
    do_reset();

    // AND/4: correct DUT over all four pairs -> pass.
    st_i[0] = 1'b1; tick();
    e = zero_rec(); e.busy = 1'b1;
    cmp_outputs(0, "start_clear", e);
    for (int i = 0; i < 4; i++) begin smp(0, i[1], i[0], 1'b0); tick(); end
    tick();

    // AND/4: y stuck at 1 -> three failures, first at index 0 pair 00.
    st_i[0] = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin smp_y(0, i[1], i[0], 1'b1); tick(); end

    // Start with a concurrent failing sample (ignored), start mid-run ignored.
    st_i[0] = 1'b1; smp_y(0, 1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) st_i[0] = 1'b1;
      smp(0, i[1], i[0], 1'b0);
      tick();
    end
    st_i[0] = 1'b1; tick();
    e = zero_rec(); e.busy = 1'b1;
    cmp_outputs(0, "restart_clear", e);

    // Reset mid-run with one failure recorded, then samples without start are ignored.
    smp_y(0, 1'b0, 1'b0, 1'b1); tick();
    smp(0, 1'b1, 1'b1, 1'b0); tick();
    do_reset();
    smp_y(0, 1'b0, 1'b0, 1'b1); tick();
    smp_y(0, 1'b1, 1'b0, 1'b1); tick();
    cmp_outputs(0, "no_start", zero_rec());
    st_i[0] = 1'b1; tick();
    smp(0, 1'b0, 1'b1, 1'b0); tick();
    smp(0, 1'b1, 1'b1, 1'b1); tick();
    smp(0, 1'b0, 1'b0, 1'b0); tick();
    smp(0, 1'b1, 1'b0, 1'b0); tick();

    // XOR/3: valid while idle ignored; pairs 00,01,11 -> coverage 1011, no pass.
    smp(1, 1'b1, 1'b1, 1'b1); tick();
    st_i[1] = 1'b1; tick();
    smp(1, 1'b0, 1'b0, 1'b0); tick();
    smp(1, 1'b0, 1'b1, 1'b0); tick();
    smp(1, 1'b1, 1'b1, 1'b0); tick();

    // AND/8 with 2-bit counter: six failures saturate at 3.
    st_i[2] = 1'b1; tick();
    for (int i = 0; i < 8; i++) begin
      smp(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (i < 6));
      tick();
    end
    tick();

    // Randomized traffic on all three checkers, with periodic resets.
    for (int c = 0; c < 600; c++) begin
      if (c % 200 == 199) do_reset();
      for (int d = 0; d < ND; d++) begin
        if (m_state[d] != 1) st_i[d] = ($urandom_range(0, 3) == 0);
        else st_i[d] = ($urandom_range(0, 19) == 0);
        v_i[d] = ($urandom_range(0, 9) < 7);
        a_i[d] = 1'($urandom_range(0, 1));
        b_i[d] = 1'($urandom_range(0, 1));
        y_i[d] = gold(op_of(d), a_i[d], b_i[d]) ^ ($urandom_range(0, 4) == 0);
      end
      tick();
    end
    tick(); tick(); tick();
    for (int d = 0; d < ND; d++) chk("queue_drain", d, mq[d].size() + dq[d].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
